down_count_timer: RTL
=====================

Name: down_count_timer

Overview:
- Loadable down-counter and timer; the count-down counterpart of the team's enable-gated up counter.
- Accepts a start value over a valid/ready load handshake and decrements once per enabled tick.
- Flags terminal count with a one-cycle pulse, then stops or auto-reloads.
- Used for timeouts and periodic event generation on the buffered internal clock domain.

Parameters:
- WIDTH, 4, width of count, load value and reload register.
- PRESCALE, 4, enable ticks per decrement; used only when DCT_PRESCALE_EN is defined; legal range 2..256.

Ports:
- clk_int  input  1  clock, already buffered upstream; all state on posedge.
- reset  input  1  asynchronous, active-high; clock clk_int.
- enable  input  1  tick qualifier; decrement only on cycles with enable=1.
- load_valid  input  1  load request.
- load_value  input  WIDTH  start value, sampled on handshake.
- load_ready  output  1  block can accept a load.
- auto_reload  input  1  sampled at terminal count: 1 = reload and continue, 0 = stop.
- stop  input  1  synchronous abort of a running count.
- count  output  WIDTH  current count value.
- tc  output  1  registered terminal-count pulse.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (async, any time, including mid-count):
  - count=0, tc=0, busy=0, load_ready=1, state=IDLE, reload register=0, prescaler=0.
- FSM states IDLE, RUN, DONE. All outputs are registered or decoded from state only.
- load_ready = 1 in IDLE and DONE, 0 in RUN. busy = 1 only in RUN.
- Handshake:
  - Load is accepted on a posedge with load_valid=1 and load_ready=1.
  - load_valid in RUN is ignored; there is no queuing.
  - Next cycle after acceptance: count=load_value, reload register=load_value.
  - If load_value != 0, state=RUN.
  - If load_value == 0, state=DONE and tc=1 for exactly that cycle.
- Tick:
  - Without DCT_PRESCALE_EN: tick = enable.
- RUN, on tick with count > 1: count <= count-1.
- RUN, on tick with count == 1 (terminal):
  - tc <= 1 for one cycle.
  - If auto_reload=1: count <= reload register, stay in RUN.
  - If auto_reload=0: count <= 0, state DONE.
- RUN, no tick: count holds.
- Latency: terminal tick on edge N gives tc high from edge N to edge N+1.
- Invariant: count >= 1 while in RUN; count never underflows or wraps through all-ones.
- stop=1 in RUN:
  - state <= IDLE; count holds its current value; no tc.
  - stop wins over a simultaneous terminal tick.
  - stop in IDLE or DONE has no effect.
- DONE: count holds 0. A new load restarts the count; the load takes precedence over stop.
- tc is 0 on every cycle other than those defined above.

Optional Feature:
- Macro: DCT_PRESCALE_EN.
- Defined:
  - A prescaler counts enable cycles; tick = enable AND prescaler == PRESCALE-1.
  - Prescaler wraps to 0 on tick.
  - Prescaler clears to 0 on accepted load, stop, and reset.
  - Prescaler is frozen outside RUN.
- Not defined: no prescaler logic is instantiated, tick = enable, and PRESCALE is ignored.

Decomposition:
- Package dct_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module dct_prescaler:
  - Holds the enable-divider counter.
  - Outputs tick.
  - Instantiated only under DCT_PRESCALE_EN.

Test Plan:
- Reset then idle:
  - Stimulus: reset asserted mid-cycle.
  - Response: count=0, tc=0, busy=0, load_ready=1 immediately (asynchronous).
- One-shot countdown:
  - Stimulus: load 4'd3, auto_reload=0, enable=1 continuously.
  - Response: count 3,2,1,0; tc high for one cycle with count=0; then DONE with load_ready=1 and busy=0.
- Auto-reload:
  - Stimulus: load 4'd2, auto_reload=1, enable=1.
  - Response: count 2,1,2,1,…; tc pulses every 2 cycles; busy stays 1.
- Gated enable and ignored load:
  - Stimulus: load 4'd5, enable toggled 1,0,1,0; load_valid with value 4'd9 while in RUN.
  - Response: count decrements only on enable cycles; the 9 is ignored.
- Stop on terminal:
  - Stimulus: stop=1 on the same edge as the count==1 tick.
  - Response: state IDLE, count=1, no tc.
  - Stimulus: load 4'd0.
  - Response: tc pulse next cycle, DONE.
- Prescaler (build with DCT_PRESCALE_EN, PRESCALE=4):
  - Stimulus: load 4'd2, enable=1.
  - Response: tc after 8 enable cycles.
  - Stimulus: reset asserted mid-count.
  - Response: prescaler and count return to 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and defaults for the down_count_timer slice.
package dct_pkg;

    localparam int unsigned DCT_WIDTH_DEFAULT    = 4;
    localparam int unsigned DCT_PRESCALE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dct_state_e;

endpackage

// File: rtl/down_count_timer_if.sv
// Load handshake bundle for down_count_timer: valid/value from the requester, ready from the timer.
interface down_count_timer_if
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH = DCT_WIDTH_DEFAULT
);
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/dct_prescaler.sv
// Enable divider: emits one tick every PRESCALE enabled cycles while running.
module dct_prescaler
    import dct_pkg::*;
#(
    parameter int unsigned PRESCALE = DCT_PRESCALE_DEFAULT
) (
    input  logic clk_int,
    input  logic reset,
    input  logic enable,
    input  logic run,
    input  logic clear,
    output logic tick_c
);
    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          at_top_c;

    assign at_top_c = (pre_q == PW'(PRESCALE - 1));
    assign tick_c   = enable && at_top_c;

    // Counter only advances in RUN so it stays frozen in IDLE/DONE.
    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (run && enable) begin
            pre_d = at_top_c ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and optional auto-reload.
// Optional enable prescaler is built when DCT_PRESCALE_EN is defined.
module down_count_timer
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH    = DCT_WIDTH_DEFAULT,
    parameter int unsigned PRESCALE = DCT_PRESCALE_DEFAULT
) (
    input  logic                     clk_int,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     auto_reload,
    input  logic                     stop,
    down_count_timer_if.slave        load_if,
    output logic [WIDTH-1:0]         count,
    output logic                     tc,
    output logic                     busy
);
    if ((PRESCALE < 2) || (PRESCALE > 256)) begin : g_bad_prescale
        $error("down_count_timer: PRESCALE must be in 2..256");
    end

    dct_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             load_acc_c;
    logic             tick_c;

    assign load_acc_c = load_if.load_valid && (state_q != RUN);

`ifdef DCT_PRESCALE_EN
    logic pre_clear_c;
    assign pre_clear_c = load_acc_c || ((state_q == RUN) && stop);

    dct_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_int (clk_int),
        .reset   (reset),
        .enable  (enable),
        .run     (state_q == RUN),
        .clear   (pre_clear_c),
        .tick_c  (tick_c)
    );
`else
    assign tick_c = enable;
`endif

    // Next-state and next-output decode; stop beats a terminal tick, load beats stop.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (load_acc_c) begin
                    count_d  = load_if.load_value;
                    reload_d = load_if.load_value;
                    if (load_if.load_value == '0) begin
                        state_d = DONE;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick_c) begin
                    if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count              = count_q;
    assign tc                 = tc_q;
    assign busy               = (state_q == RUN);
    assign load_if.load_ready = (state_q != RUN);
endmodule
